fifo_rd_sched: RTL and testbench

Read-side scheduler for the async FIFO read port (rclk domain). It shares the single FIFO read port between N_REQ consumers using round-robin arbitration, grants whole bursts, and drives read_enable only while the FIFO is non-empty. It steers returning read_data to the burst owner with valid/last tags and programs aempty_value. It sits between the consumer blocks and the FIFO read interface.

---
 rtl/fifo_rd_sched_pkg.sv | 18 +
 rtl/fifo_rd_sched_rr_arbiter.sv | 30 +++
 rtl/fifo_rd_sched.sv | 179 +++++++++++++++++
 tb/tb_fifo_rd_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and defaults for the FIFO read-port scheduler.
package fifo_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [4:0] AEMPTY_RST = 5'd4;

  localparam int DEF_N_REQ     = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr, with wrap.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  // Walk offsets from farthest to nearest so the nearest eligible requester wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin burst scheduler for the FIFO read port: grants whole bursts,
// pops only while non-empty, tags returning data with owner/valid/last.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int LEN_W     = $clog2(MAX_BURST + 1),
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       rclk,
  input  logic                       hw_rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rd_valid,
  output logic                       rd_last,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(N_REQ)-1:0]   rd_owner,
  output logic                       burst_abort,
  input  logic [4:0]                 cfg_aempty,
  output logic [4:0]                 aempty_value,
  output logic                       read_enable,
  input  logic [DATA_W-1:0]          read_data,
  input  logic                       rdempty,
  input  logic                       underflow,
  output logic                       underflow_err,
  input  logic                       err_clr,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d, rr_q, rr_d;
  logic [4:0]          aempty_q, aempty_d;
  logic                err_q, err_d, abort_q, abort_d;
  logic                rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [RD_LAT:1]     vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;

  logic [N_REQ-1:0]    elig, arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic [LEN_W-1:0]    sel_len;
  logic                final_pop, to_hit, pipe_empty;

  for (genvar i = 0; i < N_REQ; i++) begin : g_elig
    assign elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (elig),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign sel_len    = req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign final_pop  = read_enable && (rem_q == LEN_W'(1));
  assign to_hit     = (state_q == BURST) && rdempty && (to_q == TO_W'(TIMEOUT - 1));
  assign pipe_empty = (vld_pipe_q == '0);

  // State register.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state: grant, run burst until last pop or timeout, drain in-flight reads.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|elig) state_d = BURST;
      BURST:   if (final_pop || to_hit) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop only while the burst has words left and the FIFO has data.
  always_comb begin
    read_enable = (state_q == BURST) && !rdempty && (rem_q != '0);
    busy        = (state_q != IDLE);
  end

  // Datapath next values: grant capture, burst/timeout counters, return path.
  always_comb begin
    rem_d       = rem_q;
    to_d        = to_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    aempty_d    = aempty_q;
    // Oldest pipe stage is dropped; a new stage enters at the bottom.
    vld_pipe_d  = RD_LAT'({vld_pipe_q, read_enable});
    last_pipe_d = RD_LAT'({last_pipe_q, final_pop});
    rd_valid_d  = vld_pipe_q[RD_LAT];
    rd_last_d   = vld_pipe_q[RD_LAT] && last_pipe_q[RD_LAT];
    rd_data_d   = vld_pipe_q[RD_LAT] ? read_data : rd_data_q;
    abort_d     = to_hit;
    // Setting beats clearing when both land in the same cycle.
    err_d       = (err_q && !err_clr) || (underflow && read_enable);
    unique case (state_q)
      IDLE: begin
        aempty_d = cfg_aempty;
        if (|elig) begin
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          rem_d   = (sel_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : sel_len;
          to_d    = '0;
        end
      end
      BURST: begin
        if (read_enable) begin
          rem_d = rem_q - LEN_W'(1);
          to_d  = '0;
        end else if (rdempty) begin
          to_d  = to_q + TO_W'(1);
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          gnt_d = '0;
          rr_d  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards anything in flight.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      rem_q       <= '0;
      to_q        <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      aempty_q    <= AEMPTY_RST;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      rem_q       <= rem_d;
      to_q        <= to_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      aempty_q    <= aempty_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign gnt           = gnt_q;
  assign rd_owner      = owner_q;
  assign rd_valid      = rd_valid_q;
  assign rd_last       = rd_last_q;
  assign rd_data       = rd_data_q;
  assign burst_abort   = abort_q;
  assign aempty_value  = aempty_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched with a one-cycle-latency FIFO model.
module tb_fifo_rd_sched;

  logic        rclk;
  logic        hw_rst_n;
  logic [1:0]  req;
  logic [9:0]  req_len;
  logic [1:0]  gnt;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [0:0]  rd_owner;
  logic        burst_abort;
  logic [4:0]  cfg_aempty, aempty_value;
  logic        read_enable;
  logic [31:0] read_data;
  logic        rdempty, underflow, underflow_err, err_clr, busy;

  int passes = 0;
  int total  = 0;
  int fill   = 0;
  int popped = 0;

  fifo_rd_sched dut (
    .rclk(rclk), .hw_rst_n(hw_rst_n), .req(req), .req_len(req_len), .gnt(gnt),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .rd_owner(rd_owner),
    .burst_abort(burst_abort), .cfg_aempty(cfg_aempty), .aempty_value(aempty_value),
    .read_enable(read_enable), .read_data(read_data), .rdempty(rdempty),
    .underflow(underflow), .underflow_err(underflow_err), .err_clr(err_clr), .busy(busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO model: word n reads back as A000_0000+n one cycle after its pop.
  assign rdempty = (popped >= fill);
  always @(posedge rclk) begin
    if (read_enable) begin
      read_data <= 32'hA000_0000 + 32'(popped);
      popped    <= popped + 1;
    end
  end

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int en_cnt, vcnt, lcnt, lastidx, base, n, idle_seen, ovl, acnt, aidx;
    read_data  = '0;
    hw_rst_n   = 1'b0;
    req        = 2'b11;
    req_len    = {5'd4, 5'd4};
    cfg_aempty = 5'd7;
    underflow  = 1'b0;
    err_clr    = 1'b0;

    // 1: reset with requests held
    repeat (3) tick;
    chk("rst_gnt",      64'(gnt), 64'(0));
    chk("rst_ren",      64'(read_enable), 64'(0));
    chk("rst_valid",    64'(rd_valid), 64'(0));
    chk("rst_last",     64'(rd_last), 64'(0));
    chk("rst_data",     64'(rd_data), 64'(0));
    chk("rst_owner",    64'(rd_owner), 64'(0));
    chk("rst_abort",    64'(burst_abort), 64'(0));
    chk("rst_err",      64'(underflow_err), 64'(0));
    chk("rst_aempty",   64'(aempty_value), 64'(4));
    chk("rst_busy",     64'(busy), 64'(0));
    req = 2'b00;
    hw_rst_n = 1'b1;
    tick; tick;
    chk("idle_aempty",  64'(aempty_value), 64'(7));

    // 2: single 4-word burst from requester 0
    fill = popped + 10; base = popped;
    req_len = {5'd0, 5'd4}; req = 2'b01;
    tick;
    chk("t2_gnt",  64'(gnt), 64'(2'b01));
    chk("t2_busy", 64'(busy), 64'(1));
    req = 2'b00;
    en_cnt = 0; vcnt = 0; lcnt = 0; lastidx = 0;
    for (int i = 0; i < 12; i++) begin
      if (read_enable) en_cnt++;
      if (rd_valid) begin
        vcnt++;
        chk("t2_owner", 64'(rd_owner), 64'(0));
        chk("t2_data",  64'(rd_data), 64'(32'hA000_0000 + 32'(base + vcnt - 1)));
        if (rd_last) begin lcnt++; lastidx = vcnt; end
      end
      tick;
    end
    chk("t2_pops",    64'(en_cnt), 64'(4));
    chk("t2_valids",  64'(vcnt), 64'(4));
    chk("t2_lastcnt", 64'(lcnt), 64'(1));
    chk("t2_lastpos", 64'(lastidx), 64'(4));
    chk("t2_busy_end", 64'(busy), 64'(0));
    chk("t2_gnt_end",  64'(gnt), 64'(0));

    // 3: both requesting, len 2 each; fresh pointer gives order 0,1,0
    hw_rst_n = 1'b0; tick; hw_rst_n = 1'b1;
    fill = popped + 20;
    req_len = {5'd2, 5'd2}; req = 2'b11; ovl = 0;
    for (int b = 0; b < 3; b++) begin
      idle_seen = 0; n = 0;
      while (gnt == 2'b00 && n < 20) begin
        if (!busy) idle_seen = 1;
        tick; n++;
      end
      chk("t3_gnt",  64'(gnt), (b == 1) ? 64'(2'b10) : 64'(2'b01));
      chk("t3_idle", 64'(idle_seen), 64'(1));
      if (b == 2) req = 2'b00;
      vcnt = 0; n = 0;
      while (gnt != 2'b00 && n < 30) begin
        if ($countones(gnt) > 1) ovl++;
        if (rd_valid) begin
          vcnt++;
          chk("t3_owner", 64'(rd_owner), (b == 1) ? 64'(1) : 64'(0));
        end
        tick; n++;
      end
      chk("t3_words", 64'(vcnt), 64'(2));
    end
    chk("t3_overlap", 64'(ovl), 64'(0));

    // 4: 3-word burst, FIFO runs dry after one word -> timeout abort
    fill = popped + 1;
    req_len = {5'd0, 5'd3}; req = 2'b01;
    tick;
    chk("t4_gnt", 64'(gnt), 64'(2'b01));
    req = 2'b00;
    acnt = 0; aidx = -1; vcnt = 0; lcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (burst_abort) begin acnt++; aidx = i; end
      if (rd_valid) vcnt++;
      if (rd_last) lcnt++;
      tick;
    end
    chk("t4_abort_cnt", 64'(acnt), 64'(1));
    chk("t4_abort_at",  64'(aidx), 64'(65));
    chk("t4_valids",    64'(vcnt), 64'(1));
    chk("t4_nolast",    64'(lcnt), 64'(0));
    chk("t4_gnt_rel",   64'(gnt), 64'(0));
    chk("t4_busy",      64'(busy), 64'(0));

    // 5: sticky underflow error, clear, and set-vs-clear collision
    fill = popped + 10;
    req_len = {5'd0, 5'd8}; req = 2'b01;
    tick;
    chk("t5_gnt", 64'(gnt), 64'(2'b01));
    req = 2'b00;
    chk("t5_ren", 64'(read_enable), 64'(1));
    underflow = 1'b1; tick; underflow = 1'b0;
    chk("t5_set",   64'(underflow_err), 64'(1));
    tick;
    chk("t5_stick", 64'(underflow_err), 64'(1));
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("t5_clr",   64'(underflow_err), 64'(0));
    chk("t5_ren2",  64'(read_enable), 64'(1));
    underflow = 1'b1; err_clr = 1'b1; tick; underflow = 1'b0; err_clr = 1'b0;
    chk("t5_collide", 64'(underflow_err), 64'(1));
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    chk("t5_done", 64'(busy), 64'(0));

    // 6: aempty programming only lands in IDLE
    fill = popped + 10;
    req_len = {5'd0, 5'd5}; req = 2'b01;
    tick;
    chk("t6_gnt", 64'(gnt), 64'(2'b01));
    req = 2'b00; cfg_aempty = 5'd9;
    tick;
    chk("t6_hold_burst", 64'(aempty_value), 64'(7));
    n = 0;
    while (busy && n < 30) begin tick; n++; end
    chk("t6_hold_idle0", 64'(aempty_value), 64'(7));
    tick;
    chk("t6_update", 64'(aempty_value), 64'(9));

    // 6b: async reset in the middle of a burst
    fill = popped + 10;
    req_len = {5'd0, 5'd8}; req = 2'b01;
    tick;
    chk("t6_ren_pre", 64'(read_enable), 64'(1));
    #2 hw_rst_n = 1'b0;
    #1;
    chk("t6_rst_ren",    64'(read_enable), 64'(0));
    chk("t6_rst_gnt",    64'(gnt), 64'(0));
    chk("t6_rst_busy",   64'(busy), 64'(0));
    chk("t6_rst_aempty", 64'(aempty_value), 64'(4));
    chk("t6_rst_err",    64'(underflow_err), 64'(0));
    req = 2'b00;
    tick;
    hw_rst_n = 1'b1;
    tick;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
